div_unit: RTL and testbench

//   Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions.

---
 rtl/div_if.sv | 20 ++
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// div_if: handshake bundle between the pipeline control (master) and the
// iterative divider (slave).
//   start   master->slave  request a divide (sampled only while the unit is idle)
//   a, b    master->slave  dividend and divisor
//   op      master->slave  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   busy    slave->master  operation in progress, pipeline must stall
//   done    slave->master  one-cycle pulse, result valid in that cycle
//   result  slave->master  quotient or remainder, held until the next accepted start
interface div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, a, b, op, input busy, done, result);
  modport slave  (input start, a, b, op, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, WIDTH iterations, then a one-cycle sign fix-up
// and a one-cycle done pulse.
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-high reset, aborts any operation in flight
//   bus    div_if slave modport (start/a/b/op in, busy/done/result out)
// Optional build macro: DIV_EARLY_OUT_EN -- when defined, operations whose
// magnitude |a| is below |b| finish on the fast path (quotient 0, remainder a).
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   reset,
  div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_next;
  logic             sel_rem;
  logic             q_neg, r_neg;
  logic             special;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_r, quo_r, div_r, result_r;

  // Operand decode for the accept cycle
  logic             is_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, overflow, early, fast;
  logic [WIDTH-1:0] fast_quo, fast_rem;

  always_comb begin
    is_signed = ~bus.op[0];
    abs_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    div_zero  = (bus.b == '0);
    overflow  = is_signed && (bus.a == MIN_VAL) && (bus.b == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = !div_zero && !overflow && (abs_a < abs_b);
`else
    early     = 1'b0;
`endif
    fast      = div_zero || overflow || early;
    // Results for the fast cases are final values; no sign fix-up applies.
    fast_quo  = div_zero ? '1 : (overflow ? MIN_VAL : '0);
    fast_rem  = overflow ? '0 : bus.a;
  end

  // One restoring step: shift {rem,quo} left and try subtracting the divisor.
  logic [WIDTH:0] partial, trial;

  always_comb begin
    partial = {rem_r, quo_r[WIDTH-1]};
    trial   = partial - {1'b0, div_r};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Fast cases skip the iterations and resolve in a single FIX cycle, so
  // their done pulse lands one cycle after acceptance.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = fast ? FIX : RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (count == CW'(1)) state_next = FIX;
      end
      FIX: begin
        bus.busy   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_rem  <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      special  <= 1'b0;
      count    <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      div_r    <= '0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sel_rem <= bus.op[1];
            q_neg   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg   <= is_signed && bus.a[WIDTH-1];
            special <= fast;
            count   <= CW'(WIDTH);
            div_r   <= abs_b;
            if (fast) begin
              quo_r <= fast_quo;
              rem_r <= fast_rem;
            end else begin
              quo_r <= abs_a;
              rem_r <= '0;
            end
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (!trial[WIDTH]) begin
            rem_r <= trial[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= partial[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (special)      result_r <= sel_rem ? rem_r : quo_r;
          else if (sel_rem) result_r <= r_neg ? -rem_r : rem_r;
          else              result_r <= q_neg ? -quo_r : quo_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit with a behavioural reference
// model built on the simulator's own integer division.
module tb_div_unit;

  localparam int WIDTH = 32;
  localparam int SLOW_LAT = WIDTH + 1;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  div_if #(.WIDTH(WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RISC-V division semantics from plain arithmetic.
  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input bit sgn);
    if (sgn && $signed(x) < 0) return 32'd0 - x;
    return x;
  endfunction

  // Number of edges after acceptance until done is visible.
  function automatic int model_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ovf;
    ovf = !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    if (b == 32'd0 || ovf) return 1;
    if (EARLY && mag(a, !op[0]) < mag(b, !op[0])) return 1;
    return SLOW_LAT;
  endfunction

  // Issues one operation and waits for done; leaves the unit back in idle.
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat     = -1;
    res     = 32'hDEAD_BEEF;
    busy_ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.result;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_done: got %b, expected 0", bus.done);
    end
    vectors++;
    if (bus.result !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_result: got %h, expected 00000000", bus.result);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [9] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1};
    logic [31:0] as  [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5,
                             32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'd3};
    logic [31:0] bs  [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10};
    logic [31:0] exp_r [9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFB, 32'h8000_0000, 32'd0, 32'd0};
    int          exp_l [9];
    logic [31:0] res;
    int          lat;
    bit          busy_ok;
    exp_l = '{SLOW_LAT, SLOW_LAT, SLOW_LAT, SLOW_LAT, 1, 1, 1, 1, EARLY ? 1 : SLOW_LAT};
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, busy_ok);
      vectors++;
      if (res !== exp_r[i]) begin
        miscompares++;
        $display("[TB] FAIL directed_result[%0d]: got %h, expected %h", i, res, exp_r[i]);
      end
      vectors++;
      if (lat != exp_l[i]) begin
        miscompares++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d, expected %0d", i, lat, exp_l[i]);
      end
      vectors++;
      if (!busy_ok) begin
        miscompares++;
        $display("[TB] FAIL directed_busy[%0d]: got bad busy/done overlap, expected clean", i);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, res;
    int          lat;
    bit          busy_ok;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: begin a = $urandom_range(0, 50); b = $urandom_range(51, 1000); end
        4: b = b >> $urandom_range(0, 31);
        5: b = 32'd0 - $urandom_range(1, 9);
        default: ;
      endcase
      run_op(op, a, b, res, lat, busy_ok);
      vectors++;
      if (res !== model_result(op, a, b)) begin
        miscompares++;
        $display("[TB] FAIL random_result op=%0d a=%h b=%h: got %h, expected %h",
                 op, a, b, res, model_result(op, a, b));
      end
      vectors++;
      if (lat != model_latency(op, a, b)) begin
        miscompares++;
        $display("[TB] FAIL random_latency op=%0d a=%h b=%h: got %0d, expected %0d",
                 op, a, b, lat, model_latency(op, a, b));
      end
      vectors++;
      if (!busy_ok) begin
        miscompares++;
        $display("[TB] FAIL random_busy op=%0d: got bad busy/done overlap, expected clean", op);
      end
    end
  endtask

  // A second start while running must not disturb the operation in flight.
  task automatic test_ignore_start();
    int          lat;
    logic [31:0] res;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 5) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (res !== 32'd14) begin
      miscompares++;
      $display("[TB] FAIL ignore_start_result: got %h, expected 0000000e", res);
    end
    vectors++;
    if (lat != SLOW_LAT) begin
      miscompares++;
      $display("[TB] FAIL ignore_start_latency: got %0d, expected %0d", lat, SLOW_LAT);
    end
  endtask

  task automatic test_abort_reset();
    bit          done_seen;
    logic [31:0] res;
    int          lat;
    bit          busy_ok;
    done_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = (k == 5);
      if (k == 5) begin
        bus.a = 32'd1;
        bus.b = 32'd1;
      end
      if (k == 10) reset = 1'b1;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    vectors++;
    if (done_seen) begin
      miscompares++;
      $display("[TB] FAIL abort_done: got done pulse, expected none");
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_busy: got %b, expected 0", bus.busy);
    end
    vectors++;
    if (bus.result !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL abort_result: got %h, expected 00000000", bus.result);
    end
    run_op(2'd1, 32'd9, 32'd3, res, lat, busy_ok);
    vectors++;
    if (res !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL abort_recover: got %h, expected 00000003", res);
    end
  endtask

  // start held through the done cycle is ignored and accepted one cycle later.
  task automatic test_back_to_back();
    int          lat;
    logic [31:0] res;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'd5;
    bus.b     = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_done: got %b, expected 1", bus.done);
    end
    bus.start = 1'b1;
    bus.a     = 32'd20;
    bus.b     = 32'd4;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_start_in_done: got busy %b, expected 0", bus.busy);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (res !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL b2b_result: got %h, expected 00000005", res);
    end
    vectors++;
    if (lat != SLOW_LAT) begin
      miscompares++;
      $display("[TB] FAIL b2b_latency: got %0d, expected %0d", lat, SLOW_LAT);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_abort_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
